// File: rtl/aim_scheduler.sv
// AIM job scheduler: issues one AIM start per iteration and reduces match results.
// Optional WAIT-state watchdog: define AIM_SCHED_TIMEOUT_EN.
module aim_scheduler #(
  parameter int W_C_LENGTH  = 32,
  parameter int POS_W       = 9,
  parameter int ITE_W       = 3,
  parameter int CNT_W       = 10,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_job_start,
  input  logic [ITE_W-1:0]            i_num_ite,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_aim_start,
  output logic [ITE_W-1:0]            o_aim_ite,
  input  logic                        i_aim_finish,
  input  logic [W_C_LENGTH-1:0]       i_aim_valid,
  input  logic [W_C_LENGTH*POS_W-1:0] i_aim_pos,
  output logic [CNT_W-1:0]            o_ite_cnt,
  output logic                        o_ite_cnt_vld,
  output logic [CNT_W-1:0]            o_match_total,
  output logic                        o_first_found,
  output logic [ITE_W-1:0]            o_first_ite,
  output logic [POS_W-1:0]            o_first_pos,
  output logic                        o_err
);

  localparam int N_W = ITE_W + 1;
  localparam logic [N_W-1:0] ONE_N = N_W'(1);
  localparam logic [ITE_W-1:0] ONE_I = ITE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [ITE_W-1:0] ite_q, ite_d;
  logic [N_W-1:0]   num_q, num_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_q, start_d;
  logic [ITE_W-1:0] aim_ite_q, aim_ite_d;
  logic [CNT_W-1:0] ite_cnt_q, ite_cnt_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             found_q, found_d;
  logic [ITE_W-1:0] fite_q, fite_d;
  logic [POS_W-1:0] fpos_q, fpos_d;

`ifdef AIM_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  logic [CNT_W-1:0] pop;
  logic [POS_W-1:0] low_pos;
  logic [CNT_W:0]   sum;
  logic             last;

  // Walk lanes high to low so the lowest set lane wins.
  always_comb begin
    pop     = '0;
    low_pos = '0;
    for (int k = W_C_LENGTH - 1; k >= 0; k--) begin
      if (i_aim_valid[k]) begin
        low_pos = i_aim_pos[k*POS_W +: POS_W];
      end
      pop = pop + {{(CNT_W-1){1'b0}}, i_aim_valid[k]};
    end
  end

  assign sum  = {1'b0, total_q} + {1'b0, pop};
  assign last = ({1'b0, ite_q} == (num_q - ONE_N));

  always_comb begin
    state_d   = state_q;
    ite_d     = ite_q;
    num_d     = num_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    start_d   = 1'b0;
    aim_ite_d = aim_ite_q;
    ite_cnt_d = ite_cnt_q;
    vld_d     = 1'b0;
    total_d   = total_q;
    found_d   = found_q;
    fite_d    = fite_q;
    fpos_d    = fpos_q;
`ifdef AIM_SCHED_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_job_start) begin
          num_d     = (i_num_ite == '0) ? {1'b1, {ITE_W{1'b0}}}
                                        : {1'b0, i_num_ite};
          total_d   = '0;
          found_d   = 1'b0;
          fite_d    = '0;
          fpos_d    = '0;
          ite_d     = '0;
          aim_ite_d = '0;
          start_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_ISSUE;
`ifdef AIM_SCHED_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef AIM_SCHED_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (i_aim_finish) begin
          ite_cnt_d = pop;
          vld_d     = 1'b1;
          total_d   = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
          if (!found_q && (i_aim_valid != '0)) begin
            found_d = 1'b1;
            fite_d  = ite_q;
            fpos_d  = low_pos;
          end
          if (last) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            ite_d     = ite_q + ONE_I;
            aim_ite_d = ite_q + ONE_I;
            start_d   = 1'b1;
            state_d   = S_ISSUE;
          end
        end
`ifdef AIM_SCHED_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      ite_q     <= '0;
      num_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      aim_ite_q <= '0;
      ite_cnt_q <= '0;
      vld_q     <= 1'b0;
      total_q   <= '0;
      found_q   <= 1'b0;
      fite_q    <= '0;
      fpos_q    <= '0;
`ifdef AIM_SCHED_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ite_q     <= ite_d;
      num_q     <= num_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start_d;
      aim_ite_q <= aim_ite_d;
      ite_cnt_q <= ite_cnt_d;
      vld_q     <= vld_d;
      total_q   <= total_d;
      found_q   <= found_d;
      fite_q    <= fite_d;
      fpos_q    <= fpos_d;
`ifdef AIM_SCHED_TIMEOUT_EN
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`endif
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_aim_start   = start_q;
  assign o_aim_ite     = aim_ite_q;
  assign o_ite_cnt     = ite_cnt_q;
  assign o_ite_cnt_vld = vld_q;
  assign o_match_total = total_q;
  assign o_first_found = found_q;
  assign o_first_ite   = fite_q;
  assign o_first_pos   = fpos_q;
`ifdef AIM_SCHED_TIMEOUT_EN
  assign o_err         = err_q;
`else
  assign o_err         = 1'b0;
`endif

endmodule

// File: tb/tb_aim_scheduler.sv
// Self-checking bench for aim_scheduler with a job-level reference model.
// Timeout scenario follows AIM_SCHED_TIMEOUT_EN.
module tb_aim_scheduler;
  localparam int W  = 32;
  localparam int PW = 9;
  localparam int IW = 3;
  localparam int CW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            job_start;
  logic [IW-1:0]   num_ite;
  logic            busy, done, aim_start;
  logic [IW-1:0]   aim_ite;
  logic            finish;
  logic [W-1:0]    valid;
  logic [W*PW-1:0] pos;
  logic [CW-1:0]   ite_cnt;
  logic            ite_vld;
  logic [CW-1:0]   total;
  logic            ffound;
  logic [IW-1:0]   fite;
  logic [PW-1:0]   fpos;
  logic            err;

  aim_scheduler dut (
    .i_clk(clk), .i_rst(rst), .i_job_start(job_start),
    .i_num_ite(num_ite), .o_busy(busy), .o_done(done),
    .o_aim_start(aim_start), .o_aim_ite(aim_ite),
    .i_aim_finish(finish), .i_aim_valid(valid), .i_aim_pos(pos),
    .o_ite_cnt(ite_cnt), .o_ite_cnt_vld(ite_vld),
    .o_match_total(total), .o_first_found(ffound),
    .o_first_ite(fite), .o_first_pos(fpos), .o_err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int m_n, m_total, m_cnt, m_fite, m_fpos;
  bit m_found;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int popc(input logic [W-1:0] v);
    int c = 0;
    for (int k = 0; k < W; k++) c += int'(v[k]);
    return c;
  endfunction

  task automatic model_accept(input int i, input logic [W-1:0] v,
                              input logic [W*PW-1:0] p);
    m_cnt = popc(v);
    m_total = m_total + m_cnt;
    if (m_total > 1023) m_total = 1023;
    if (!m_found && v != 0) begin
      m_found = 1;
      m_fite = i;
      for (int k = W - 1; k >= 0; k--)
        if (v[k]) m_fpos = int'(p[k*PW +: PW]);
    end
  endtask

  task automatic rand_vec(input int dens, output logic [W-1:0] v,
                          output logic [W*PW-1:0] p);
    for (int k = 0; k < W; k++) p[k*PW +: PW] = PW'($urandom);
    case (dens)
      0: v = '0;
      1: v = $urandom & $urandom & $urandom;
      default: v = '1;
    endcase
  endtask

  task automatic start_job(input int n_raw);
    job_start = 1'b1;
    num_ite = IW'(n_raw);
    step();
    job_start = 1'b0;
    m_n = (n_raw == 0) ? 8 : n_raw;
    m_total = 0; m_found = 0; m_fite = 0; m_fpos = 0; m_cnt = 0;
    n_chk++;
    if ({aim_start, busy, aim_ite, total, ffound, err} !==
        {1'b1, 1'b1, {IW{1'b0}}, {CW{1'b0}}, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL start_job: start=%b busy=%b ite=%0d tot=%0d ff=%b err=%b, want 1 1 0 0 0 0",
               aim_start, busy, aim_ite, total, ffound, err);
    end
  endtask

  task automatic do_iter(input int i, input int d, input logic [W-1:0] v,
                         input logic [W*PW-1:0] p, input bit disturb);
    n_chk++;
    if (aim_start !== 1'b1 || aim_ite !== IW'(i)) begin
      n_fail++;
      $display("FAIL issue ite%0d: start=%b ite=%0d, want 1 %0d", i, aim_start, aim_ite, i);
    end
    if (disturb) begin
      finish = 1'b1;
      valid = '1;
    end
    step();
    finish = 1'b0;
    n_chk++;
    if (aim_start !== 1'b0 || aim_ite !== IW'(i) || ite_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL wait ite%0d: start=%b ite=%0d vld=%b, want 0 %0d 0",
               i, aim_start, aim_ite, ite_vld, i);
    end
    for (int c = 0; c < d; c++) begin
      job_start = disturb;
      step();
      job_start = 1'b0;
      n_chk++;
      if (aim_start !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || ite_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL hold ite%0d: start=%b done=%b busy=%b vld=%b, want 0 0 1 0",
                 i, aim_start, done, busy, ite_vld);
      end
    end
    job_start = disturb;
    finish = 1'b1;
    valid = v;
    pos = p;
    step();
    job_start = 1'b0;
    finish = 1'b0;
    valid = '0;
    model_accept(i, v, p);
    n_chk++;
    if (ite_vld !== 1'b1 || ite_cnt !== CW'(m_cnt) || total !== CW'(m_total)) begin
      n_fail++;
      $display("FAIL accept ite%0d: vld=%b cnt=%0d tot=%0d, want 1 %0d %0d",
               i, ite_vld, ite_cnt, total, m_cnt, m_total);
    end
    n_chk++;
    if (ffound !== m_found || (m_found && (fite !== IW'(m_fite) || fpos !== PW'(m_fpos)))) begin
      n_fail++;
      $display("FAIL first ite%0d: ff=%b fi=%0d fp=%0d, want %b %0d %0d",
               i, ffound, fite, fpos, m_found, m_fite, m_fpos);
    end
    n_chk++;
    if (done !== (i == m_n - 1) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done ite%0d: done=%b busy=%b, want %b 1", i, done, busy, i == m_n - 1);
    end
  endtask

  task automatic end_job();
    step();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || aim_start !== 1'b0 || total !== CW'(m_total)) begin
      n_fail++;
      $display("FAIL end_job: done=%b busy=%b start=%b tot=%0d, want 0 0 0 %0d",
               done, busy, aim_start, total, m_total);
    end
  endtask

  task automatic run_job(input int n_raw, input int dmax, input bit disturb);
    logic [W-1:0] v;
    logic [W*PW-1:0] p;
    start_job(n_raw);
    for (int i = 0; i < m_n; i++) begin
      rand_vec($urandom_range(2), v, p);
      do_iter(i, $urandom_range(dmax), v, p, disturb);
    end
    end_job();
  endtask

  task automatic check_all_zero(input string nm);
    n_chk++;
    if ({busy, done, aim_start, aim_ite, ite_cnt, ite_vld, total,
         ffound, fite, fpos, err} !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs busy=%b done=%b st=%b ite=%0d cnt=%0d vld=%b tot=%0d ff=%b fi=%0d fp=%0d err=%b, want all 0",
               nm, busy, done, aim_start, aim_ite, ite_cnt, ite_vld, total, ffound, fite, fpos, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_single();
    logic [W-1:0] v;
    logic [W*PW-1:0] p;
    rand_vec(0, v, p);
    v = '0;
    v[0] = 1'b1;
    v[5] = 1'b1;
    p[0 +: PW] = 9'd17;
    p[5*PW +: PW] = 9'd40;
    start_job(1);
    do_iter(0, 2, v, p, 0);
    n_chk++;
    if (ite_cnt !== 10'd2 || total !== 10'd2 || fpos !== 9'd17 || fite !== 3'd0) begin
      n_fail++;
      $display("FAIL single: cnt=%0d tot=%0d fp=%0d fi=%0d, want 2 2 17 0",
               ite_cnt, total, fpos, fite);
    end
    end_job();
  endtask

  task automatic test_all_lanes();
    logic [W-1:0] v;
    logic [W*PW-1:0] p;
    start_job(0);
    for (int i = 0; i < 8; i++) begin
      rand_vec(2, v, p);
      do_iter(i, 0, v, p, 0);
    end
    n_chk++;
    if (total !== 10'd256) begin
      n_fail++;
      $display("FAIL all_lanes_total: tot=%0d, want 256", total);
    end
    end_job();
  endtask

  task automatic test_ignore();
    run_job(3, 2, 1);
    finish = 1'b1;
    valid = '1;
    step();
    finish = 1'b0;
    valid = '0;
    step();
    n_chk++;
    if (busy !== 1'b0 || aim_start !== 1'b0 || ite_vld !== 1'b0 || total !== CW'(m_total)) begin
      n_fail++;
      $display("FAIL idle_finish: busy=%b st=%b vld=%b tot=%0d, want 0 0 0 %0d",
               busy, aim_start, ite_vld, total, m_total);
    end
  endtask

  task automatic test_first_late();
    logic [W-1:0] v;
    logic [W*PW-1:0] p;
    start_job(4);
    for (int i = 0; i < 3; i++) begin
      rand_vec(0, v, p);
      do_iter(i, 1, v, p, 0);
    end
    rand_vec(0, v, p);
    v[31] = 1'b1;
    p[31*PW +: PW] = 9'd511;
    do_iter(3, 0, v, p, 0);
    n_chk++;
    if (ffound !== 1'b1 || fite !== 3'd3 || fpos !== 9'd511 || total !== 10'd1) begin
      n_fail++;
      $display("FAIL first_late: ff=%b fi=%0d fp=%0d tot=%0d, want 1 3 511 1",
               ffound, fite, fpos, total);
    end
    end_job();
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] v;
    logic [W*PW-1:0] p;
    start_job(4);
    for (int i = 0; i < 2; i++) begin
      rand_vec(2, v, p);
      do_iter(i, 0, v, p, 0);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("mid_reset");
    finish = 1'b1;
    valid = '1;
    step();
    finish = 1'b0;
    valid = '0;
    check_all_zero("finish_after_reset");
    run_job(3, 1, 0);
  endtask

  task automatic test_timeout();
    logic [W-1:0] v;
    logic [W*PW-1:0] p;
    int dn = 0;
    start_job(2);
    rand_vec(1, v, p);
    do_iter(0, 0, v, p, 0);
    step();
`ifdef AIM_SCHED_TIMEOUT_EN
    for (int c = 0; c < 255; c++) begin
      step();
      dn += int'(done);
    end
    n_chk++;
    if (dn != 0 || busy !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_timeout: dones=%0d busy=%b err=%b, want 0 1 0", dn, busy, err);
    end
    step();
    n_chk++;
    if (done !== 1'b1 || err !== 1'b1 || total !== CW'(m_total)) begin
      n_fail++;
      $display("FAIL timeout: done=%b err=%b tot=%0d, want 1 1 %0d", done, err, total, m_total);
    end
    step();
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL post_timeout: busy=%b done=%b err=%b, want 0 0 1", busy, done, err);
    end
`else
    for (int c = 0; c < 300; c++) begin
      step();
      dn += int'(done);
    end
    n_chk++;
    if (dn != 0 || busy !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout: dones=%0d busy=%b err=%b, want 0 1 0", dn, busy, err);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("reset_after_stall");
`endif
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) run_job($urandom_range(7), 3, 0);
  endtask

  initial begin
    rst = 1'b1;
    job_start = 1'b0;
    num_ite = '0;
    finish = 1'b0;
    valid = '0;
    pos = '0;
    test_reset();
    test_single();
    test_all_lanes();
    test_ignore();
    test_first_late();
    test_mid_reset();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached, want completion");
    $fatal(1);
  end
endmodule

// File: doc/aim_scheduler.md
Name: aim_scheduler

Overview:
Sequences the AIM index-matching engine over a multi-iteration job. Accepts a job request, walks i_ite from 0 to N-1, issues one AIM start pulse per iteration and waits for AIM finish. Reduces each iteration's valid vector into per-iteration and job-total match counts, and records the first match position. Sits between the top-level control FSM and the AIM datapath.

Parameters:
W_C_LENGTH, 32, number of AIM output lanes (valid/pos entries)
POS_W, 9, width of each AIM position output
ITE_W, 3, width of AIM iteration index
CNT_W, 10, width of match counters
TIMEOUT_CYC, 256, WAIT-state cycle limit (used only with AIM_SCHED_TIMEOUT_EN)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_job_start  in  1  job request pulse
i_num_ite  in  ITE_W  iterations per job; 0 means 2^ITE_W
o_busy  out  1  job in progress
o_done  out  1  one-cycle job-complete pulse
o_aim_start  out  1  one-cycle start pulse to AIM
o_aim_ite  out  ITE_W  iteration index to AIM, stable from ISSUE through WAIT
i_aim_finish  in  1  AIM finish, qualifies i_aim_valid/i_aim_pos
i_aim_valid  in  W_C_LENGTH  per-lane match valid
i_aim_pos  in  W_C_LENGTH*POS_W  per-lane position, lane k at bits [k*POS_W +: POS_W]
o_ite_cnt  out  CNT_W  popcount of last accepted iteration
o_ite_cnt_vld  out  1  one-cycle pulse, o_ite_cnt updated
o_match_total  out  CNT_W  running job total
o_first_found  out  1  at least one match seen this job
o_first_ite  out  ITE_W  iteration of first match
o_first_pos  out  POS_W  pos of lowest-index valid lane in first matching iteration
o_err  out  1  sticky timeout flag (0 without macro)

Behaviour:
- All outputs registered. Reset: state IDLE, every output 0, internal ite counter 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: o_busy=0. If i_job_start=1, latch i_num_ite (0 maps to 2^ITE_W), clear o_match_total, o_first_*, o_err, ite=0, go ISSUE. o_busy=1 from the next cycle.
- ISSUE: o_aim_start=1 for exactly this cycle, o_aim_ite=ite. Unconditionally go WAIT. An i_aim_finish in this cycle is ignored.
- WAIT: hold o_aim_ite. On i_aim_finish=1, sample valid/pos in the same cycle. popcount(valid) goes to o_ite_cnt and is added to o_match_total. o_ite_cnt_vld pulses the next cycle.
- First-match capture: if o_first_found=0 and valid!=0, set o_first_found=1, o_first_ite=ite, and o_first_pos=pos of the lowest-index set lane.
- WAIT exit: if ite==N-1 go DONE, else ite++ and go ISSUE. Minimum per-iteration period is 2 cycles (ISSUE plus a WAIT with immediate finish).
- DONE: o_done=1 and o_busy=1 for one cycle, then IDLE.
- Result outputs (o_match_total, o_first_*, o_ite_cnt, o_err) hold until the next accepted job start.
- i_job_start outside IDLE is ignored; it is not queued.
- i_aim_finish in IDLE, ISSUE or DONE is ignored.
- o_match_total saturates at 2^CNT_W-1; no wrap.
- Latency: job_start sampled at edge k gives o_aim_start=1 during cycle k+1.
- Reset mid-job: the next edge returns to IDLE with all outputs 0. A pending AIM finish arriving afterwards is ignored.

Optional Feature:
AIM_SCHED_TIMEOUT_EN
- Defined: a counter clears on WAIT entry and increments each WAIT cycle without finish. At TIMEOUT_CYC cycles, set o_err=1 (sticky until next job start) and go DONE. o_done pulses; totals keep their partial values.
- Undefined: no counter, o_err tied 0, WAIT waits indefinitely.

Test Plan:
1. Reset; job i_num_ite=1; finish 3 cycles after start with valid lanes 0 and 5, pos0=17, pos5=40 -> one o_aim_start with ite=0; o_ite_cnt=2 with a vld pulse; o_match_total=2; o_first_pos=17; o_first_ite=0; one o_done pulse; o_busy low afterwards.
2. i_num_ite=0, all 32 lanes valid, immediate finish each iteration -> 8 start pulses at ite 0..7, spaced 2 cycles apart; o_match_total=256; o_done once.
3. i_job_start pulsed during WAIT and i_aim_finish pulsed in IDLE and in ISSUE -> no extra job, no count change, no state change.
4. i_num_ite=4, first matches only in ite 3 at lane 31 with pos=511 -> o_first_found=1, o_first_ite=3, o_first_pos=511; earlier o_ite_cnt values 0.
5. i_rst asserted during WAIT of ite 2 -> next cycle all outputs 0 and IDLE; a later finish is ignored; a new job restarts at ite 0.
6. With AIM_SCHED_TIMEOUT_EN, no finish for 256 WAIT cycles in ite 1 -> o_err=1, o_done pulse, o_match_total keeps the ite-0 count. Without the macro -> o_busy stays 1 and o_err=0.
